// File: rtl/ysyx_25040109_mdu.sv
// Iterative RV32M multiply/divide unit: one shared radix-2 datapath,
// valid/ready request and response channels toward the EXU.
module ysyx_25040109_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_op;
  logic                r_neg1;
  logic                r_neg2;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN:0]       r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_signed1;
  logic                w_signed2;
  logic                w_neg1;
  logic                w_neg2;
  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;
  logic                w_div_zero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_result;
  logic                w_last;

  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_prod_step;
  logic [XLEN:0]       w_rem_shift;
  logic [XLEN:0]       w_rem_diff;
  logic [XLEN:0]       w_rem_step;
  logic [XLEN-1:0]     w_quo_step;
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_quo_fix;
  logic [XLEN-1:0]     w_rem_fix;
  logic [XLEN-1:0]     w_calc_result;

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign resp_result = r_result;

  assign w_accept  = req_valid && (r_state == S_IDLE) && !flush;
  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU leaves rs2 unsigned
  assign w_signed1 = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
  assign w_signed2 = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
  assign w_neg1    = w_signed1 && req_src1[XLEN-1];
  assign w_neg2    = w_signed2 && req_src2[XLEN-1];
  assign w_mag1    = w_neg1 ? (~req_src1 + 1'b1) : req_src1;
  assign w_mag2    = w_neg2 ? (~req_src2 + 1'b1) : req_src2;

  assign w_div_zero = req_op[2] && (req_src2 == '0);
  assign w_ovf      = ((req_op == 3'd4) || (req_op == 3'd6)) &&
                      (req_src1 == MIN_NEG) && (req_src2 == ALL_ONE);
  assign w_special  = w_div_zero || w_ovf;
  // req_op[1] separates REM/REMU from DIV/DIVU
  assign w_special_result = w_div_zero ? (req_op[1] ? req_src1 : ALL_ONE)
                                       : (req_op[1] ? '0 : MIN_NEG);

  assign w_last = (r_cnt == CNT_W'(XLEN-1));

  // Shift-add: low half of r_prod holds the remaining multiplier bits
  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_step = {w_mul_sum, r_prod[XLEN-1:1]};

  assign w_rem_shift = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_b};
  assign w_rem_step  = w_rem_diff[XLEN] ? w_rem_shift : w_rem_diff;
  assign w_quo_step  = {r_quo[XLEN-2:0], ~w_rem_diff[XLEN]};

  assign w_prod_fix = (r_neg1 ^ r_neg2) ? (~w_prod_step + 1'b1) : w_prod_step;
  assign w_quo_fix  = (r_neg1 ^ r_neg2) ? (~w_quo_step + 1'b1) : w_quo_step;
  assign w_rem_fix  = r_neg1 ? (~w_rem_step[XLEN-1:0] + 1'b1) : w_rem_step[XLEN-1:0];

  always_comb begin
    w_calc_result = w_rem_fix;
    case (r_op)
      3'd0:                w_calc_result = w_prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_calc_result = w_prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_calc_result = w_quo_fix;
      default:             w_calc_result = w_rem_fix;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (req_valid) w_state_next = w_special ? S_DONE : S_CALC;
        S_CALC:  if (w_last) w_state_next = S_DONE;
        S_DONE:  if (resp_ready) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op   <= req_op;
        r_neg1 <= w_neg1;
        r_neg2 <= w_neg2;
        r_a    <= w_mag1;
        r_b    <= w_mag2;
        r_prod <= {{XLEN{1'b0}}, w_mag2};
        r_rem  <= '0;
        r_quo  <= w_mag1;
        r_cnt  <= '0;
        if (w_special) r_result <= w_special_result;
      end else if ((r_state == S_CALC) && !flush) begin
        r_prod <= w_prod_step;
        r_rem  <= w_rem_step;
        r_quo  <= w_quo_step;
        r_cnt  <= r_cnt + 1'b1;
        if (w_last) r_result <= w_calc_result;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_mdu.sv
// Directed and randomized checks of the MDU with a result scoreboard.
module tb_ysyx_25040109_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_25040109_mdu #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s, p;
    logic [63:0]        up;
    logic signed [31:0] s1, s2;
    logic               ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ub_s = {32'b0, b};
    s1   = a;
    s2   = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(s1 / s2);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(s1 % s2);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    exp_q.push_back(ref_mdu(op, a, b));
  endtask

  task automatic wait_resp(input string tag, input int exp_lat);
    int   lat = 0;
    logic ready_seen;
    ready_seen = req_ready;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (req_ready !== 1'b0) ready_seen = 1'b1;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " req_ready low"}, ready_seen, 1'b0);
    if (exp_q.size() > 0) check(tag, resp_result, exp_q.pop_front());
    else check({tag, " scoreboard"}, 32'd0, 32'd1);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, " resp_valid drop"}, resp_valid, 1'b0);
    check({tag, " req_ready back"}, req_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    send(op, a, b);
    wait_resp(tag, ref_lat(op, a, b));
    consume(tag);
    $display("[TB] %s op=%0d a=%h b=%h -> %h", tag, op, a, b, resp_result);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        seen;
    logic [31:0] held;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset resp_result", resp_result, 32'd0);
    check("reset busy", busy, 1'b0);
    check("reset req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    run("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD);
    run("MULH",   3'd1, 32'h8000_0000,  32'h8000_0000);
    run("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2);
    run("REM",    3'd6, 32'hFFFF_FFF9,  32'd2);
    run("REM neg divisor", 3'd6, 32'd7, 32'hFFFF_FFFE);
    run("DIVU",   3'd5, 32'd100,        32'd7);
    run("REMU",   3'd7, 32'd100,        32'd7);
    run("DIVU by0", 3'd5, 32'd5,        32'd0);
    run("REM by0",  3'd6, 32'd5,        32'd0);
    run("DIV ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run("REM ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run("DIV min/1", 3'd4, 32'h8000_0000, 32'd1);

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      run("random", op, a, b);
    end

    // backpressure: result and req_ready must hold while resp_ready is low
    send(3'd5, 32'd100, 32'd7);
    wait_resp("bp DIVU", 32);
    held = resp_result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp result stable", resp_result, 32'd14);
      check("bp req_ready low", req_ready, 1'b0);
      check("bp resp_valid held", resp_valid, 1'b1);
    end
    $display("[TB] backpressure held %h for 10 cycles", held);
    consume("bp");
    run("after bp", 3'd0, 32'd6, 32'd9);

    // flush during iteration 15
    send(3'd0, 32'd123, 32'd456);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("flush mid busy", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    check("flush busy", busy, 1'b0);
    check("flush resp_valid", resp_valid, 1'b0);
    check("flush req_ready", req_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    check("flush no late resp", seen, 1'b0);
    $display("[TB] flush at iteration 15 dropped the MUL");

    // request together with flush in IDLE is refused
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'd2; req_src2 = 32'd2; flush = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush+req not accepted", busy, 1'b0);
    $display("[TB] request with flush refused");

    run("MUL 3x4", 3'd0, 32'd3, 32'd4);

    // asynchronous reset in the middle of CALC
    send(3'd4, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid resp_valid", resp_valid, 1'b0);
    check("rst mid resp_result", resp_result, 32'd0);
    check("rst mid busy", busy, 1'b0);
    check("rst mid req_ready", req_ready, 1'b1);
    exp_q.delete();
    $display("[TB] reset mid-CALC cleared outputs");
    @(negedge clk);
    rst_n = 1'b1;
    run("after reset", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_mdu.md
Name: ysyx_25040109_mdu

Overview:
- Multi-cycle RV32M multiply/divide responder.
- EXU is the initiator: it issues an operation over a valid/ready request channel and stalls until the result returns on a valid/ready response channel.
- Replaces the single-cycle combinational `*`, `/` and `%` paths in the EXU with one shared iterative radix-2 datapath.
- Sits beside the EXU; its result is muxed into the EXU writeback result.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  EXU presents an operation.
- req_ready  out  1  MDU can accept; high only in IDLE.
- req_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_src1  in  XLEN  rs1 value.
- req_src2  in  XLEN  rs2 value.
- flush  in  1  synchronous abort; drops any in-flight or pending result.
- resp_valid  out  1  result available.
- resp_ready  in  1  EXU consumes the result.
- resp_result  out  XLEN  result; held stable while resp_valid && !resp_ready.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - resp_valid = 0, resp_result = 0, busy = 0, counter = 0.
  - req_ready = 1 once rst_n is high.
  - Reset asserted mid-operation discards all state immediately.
- States: IDLE, CALC, DONE.
- IDLE:
  - A handshake is req_valid && req_ready at edge T.
  - On a handshake, latch the op and operand magnitudes, and record sign flags: neg1 = signed-op && src1[31]; neg2 = signed-op && src2[31].
  - Signed operands: MULH both; MULHSU src1 only; DIV/REM both.
  - Special cases go straight to DONE; resp_valid rises after edge T (visible in cycle T+1):
    - DIV/DIVU with src2 == 0 -> 0xFFFFFFFF.
    - REM/REMU with src2 == 0 -> src1.
    - DIV with src1 == 0x80000000 && src2 == 0xFFFFFFFF -> 0x80000000.
    - REM with the same operands -> 0.
  - Otherwise go to CALC with counter = 0.
- CALC: exactly XLEN cycles, one iteration per edge.
  - Multiply: unsigned shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring division on magnitudes; 33-bit partial remainder, 32-bit quotient.
  - After the iteration with counter == XLEN-1, apply sign fix-up and go to DONE.
  - Net effect: resp_valid is first high in cycle T+33.
- Sign fix-up:
  - Product is negated (64-bit two's complement) when neg1 ^ neg2.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Quotient is negated when neg1 ^ neg2.
  - Remainder is negated when neg1 (takes the dividend's sign).
- DONE:
  - resp_valid = 1 and resp_result holds.
  - On resp_valid && resp_ready go to IDLE. req_ready rises the next cycle; there is no same-cycle back-to-back accept.
- flush:
  - In any state, go to IDLE on the next edge with resp_valid = 0.
  - flush has priority over completion and over resp_ready.
  - A request presented together with flush in IDLE is not accepted.
- Interface rules:
  - req_* inputs are ignored outside a handshake; operands may change freely while in CALC.
  - Undriven or unknown op values cannot occur; req_op is 3 bits and fully decoded.
- Width rules: all arithmetic is unsigned on magnitudes. |0x80000000| = 0x80000000 is representable in 32-bit unsigned and needs no special handling except the DIV/REM overflow case above.

Test Plan:
- MUL: src1 = 7, src2 = 0xFFFFFFFD -> result 0xFFFFFFEB, resp_valid first high 33 cycles after accept; req_ready low throughout.
- MULH and MULHSU:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- Signed division: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- Special cases, each with resp_valid one cycle after accept:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REM 5 % 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Backpressure: hold resp_ready = 0 for 10 cycles after resp_valid -> resp_result stable, req_ready = 0. Then pulse resp_ready -> IDLE next cycle, and a second request is accepted.
- Flush and reset mid-operation:
  - flush at iteration 15 -> IDLE next cycle, no resp_valid.
  - A subsequent MUL 3 × 4 -> 12.
  - rst_n low mid-CALC -> all outputs reset values immediately.
